update_knn_mac_pipe: RTL

UPDATE_KNN_MAC_PIPE -- requirements
Module: update_knn_mac_pipe

---
 rtl/update_knn_mac_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/update_knn_mac_pipe.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready flow control.
// Operands -> product -> delay stages -> output register with group accumulator.
module update_knn_mac_pipe #(
  parameter int DIN0_WIDTH = 17,
  parameter int DIN1_WIDTH = 15,
  parameter int DOUT_WIDTH = 48,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  acc_en,
  input  logic                  last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int MS = DOUT_WIDTH - 1;

  logic                  adv;
  logic [NUM_STAGE:1]    v;
  logic [NUM_STAGE:1]    ae;
  logic [NUM_STAGE:1]    ls;
  logic [DIN0_WIDTH-1:0] a0;
  logic [DIN1_WIDTH-1:0] a1;
  logic [PW-1:0]         pr [2:NUM_STAGE];
  logic [PW-1:0]         x0;
  logic [PW-1:0]         x1;
  logic [PW-1:0]         prod;
  logic [DOUT_WIDTH-1:0] pe;
  logic [DOUT_WIDTH-1:0] acc;
  logic [DOUT_WIDTH-1:0] sum;
  logic [DOUT_WIDTH:0]   wide;
  logic                  sticky;
  logic                  wrap;
  logic                  emit_p;
  logic                  add_only;
  logic                  emit_sum;

  // Whole pipe moves as one; a held result blocks everything behind it.
  assign adv      = ce && (!out_valid || out_ready);
  assign in_ready = adv;

  // Full-width product of the stage-1 operands, extended to PW first.
  always_comb begin
    x0 = '0;
    x1 = '0;
    if (SIGNED != 0) begin
      x0 = PW'($signed(a0));
      x1 = PW'($signed(a1));
    end else begin
      x0 = PW'(a0);
      x1 = PW'(a1);
    end
    prod = x0 * x1;
  end

  // Operand, product and delay stages carrying valid and sideband.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v  <= '0;
      ae <= '0;
      ls <= '0;
      a0 <= '0;
      a1 <= '0;
      for (int k = 2; k <= NUM_STAGE; k++)
        pr[k] <= '0;
    end else if (adv) begin
      v[1]  <= in_valid;
      ae[1] <= acc_en;
      ls[1] <= last;
      a0    <= din0;
      a1    <= din1;
      pr[2] <= prod;
      for (int k = 2; k <= NUM_STAGE; k++) begin
        v[k]  <= v[k-1];
        ae[k] <= ae[k-1];
        ls[k] <= ls[k-1];
      end
      for (int k = 3; k <= NUM_STAGE; k++)
        pr[k] <= pr[k-1];
    end
  end

  // Extend the final product, add to the accumulator, detect wrap.
  always_comb begin
    pe = '0;
    if (SIGNED != 0)
      pe = DOUT_WIDTH'($signed(pr[NUM_STAGE]));
    else
      pe = DOUT_WIDTH'(pr[NUM_STAGE]);
    wide = {1'b0, acc} + {1'b0, pe};
    sum  = wide[DOUT_WIDTH-1:0];
    if (SIGNED != 0)
      wrap = (acc[MS] == pe[MS]) && (sum[MS] != acc[MS]);
    else
      wrap = wide[DOUT_WIDTH];
    emit_p   = v[NUM_STAGE] && !ae[NUM_STAGE];
    add_only = v[NUM_STAGE] && ae[NUM_STAGE] && !ls[NUM_STAGE];
    emit_sum = v[NUM_STAGE] && ae[NUM_STAGE] && ls[NUM_STAGE];
  end

  // Output register and group accumulator; groups close on last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      sticky    <= 1'b0;
    end else if (adv) begin
      unique case (1'b1)
        emit_p: begin
          out_valid <= 1'b1;
          dout      <= pe;
          ovf       <= 1'b0;
        end
        add_only: begin
          out_valid <= 1'b0;
          acc       <= sum;
          sticky    <= sticky | wrap;
        end
        emit_sum: begin
          out_valid <= 1'b1;
          dout      <= sum;
          ovf       <= sticky | wrap;
          acc       <= '0;
          sticky    <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
